// File: rtl/write_back_sel_if.sv
// Write-back request/result bundle shared between the pipeline and write_back_sel.
// The master drives the request side. The slave returns the registered result and status.
interface write_back_sel_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4
);
  localparam int SEL_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC*WIDTH-1:0] Sources;
  logic [SEL_W-1:0]         Sel;
  logic                     InValid;
  logic                     IsLoad;
  logic                     MemReady;
  logic                     Stall;
  logic                     Flush;
  logic [WIDTH-1:0]         WMux;
  logic                     OutValid;
  logic                     Busy;
  logic                     Timeout;

  modport master (
    output Sources, Sel, InValid, IsLoad, MemReady, Stall, Flush,
    input  WMux, OutValid, Busy, Timeout
  );

  modport slave (
    input  Sources, Sel, InValid, IsLoad, MemReady, Stall, Flush,
    output WMux, OutValid, Busy, Timeout
  );
endinterface

// File: rtl/write_back_sel.sv
// Write-back source selector with a wait state for late memory data.
// The wait for memory data has a bounded number of non-stalled cycles.
module write_back_sel #(
  parameter int WIDTH       = 8,
  parameter int NUM_SRC     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  write_back_sel_if.slave   bus
);
  localparam int SEL_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic [SEL_W-1:0]   cap_sel;
  logic [WIDTH-1:0]   sel_val;
  logic [WIDTH-1:0]   wmux;
  logic               capture;
  logic               timeout_n;
  logic               out_valid;
  logic               timeout;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = sel_q;
    cap_sel   = bus.Sel;
    capture   = 1'b0;
    timeout_n = 1'b0;
    if (bus.Flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.InValid && !bus.Stall) begin
            if (!bus.IsLoad || bus.MemReady) begin
              capture = 1'b1;
            end else begin
              sel_n   = bus.Sel;
              cnt_n   = '0;
              state_n = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          cap_sel = sel_q;
          // MemReady is checked first so data arriving on the deadline still wins
          if (!bus.Stall) begin
            if (bus.MemReady) begin
              capture = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
            end else if (cnt == LAST_CNT) begin
              timeout_n = 1'b1;
              cnt_n     = '0;
              state_n   = IDLE;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Indices with no matching source fall through to zero
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cap_sel == SEL_W'(i)) sel_val = bus.Sources[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_q     <= '0;
      wmux      <= '0;
      out_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sel_q     <= sel_n;
      out_valid <= capture;
      timeout   <= timeout_n;
      if (capture) wmux <= sel_val;
    end
  end

  assign bus.WMux     = wmux;
  assign bus.OutValid = out_valid;
  assign bus.Timeout  = timeout;
  assign bus.Busy     = (state == WAIT_MEM);
endmodule

// File: tb/tb_write_back_sel.sv
// Self-checking bench for write_back_sel: a 4-source instance and a 3-source instance.
// Both instances use MEM_TIMEOUT=4. Expected captures go through per-instance scoreboard queues.
module tb_write_back_sel;
  logic CLK = 1'b0;
  logic Reset;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_v;

  write_back_sel_if #(.WIDTH(8), .NUM_SRC(4)) ifa ();
  write_back_sel_if #(.WIDTH(8), .NUM_SRC(3)) ifb ();

  write_back_sel #(.WIDTH(8), .NUM_SRC(4), .MEM_TIMEOUT(4)) dut_a (
    .CLK(CLK), .Reset(Reset), .bus(ifa.slave)
  );
  write_back_sel #(.WIDTH(8), .NUM_SRC(3), .MEM_TIMEOUT(4)) dut_b (
    .CLK(CLK), .Reset(Reset), .bus(ifb.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.InValid = 0; ifa.IsLoad = 0; ifa.MemReady = 0; ifa.Stall = 0; ifa.Flush = 0;
    ifb.InValid = 0; ifb.IsLoad = 0; ifb.MemReady = 0; ifb.Stall = 0; ifb.Flush = 0;
  endtask

  task automatic test_reset();
    Reset = 1;
    ifa.InValid = 1; ifa.Flush = 1; ifa.Stall = 1;
    tick();
    tick();
    Reset = 0;
    idle_inputs();
    checks++;
    if (ifa.WMux !== 8'h00 || ifa.OutValid !== 1'b0 || ifa.Busy !== 1'b0 || ifa.Timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_a: WMux=%h OutValid=%b Busy=%b Timeout=%b, required 00/0/0/0",
               ifa.WMux, ifa.OutValid, ifa.Busy, ifa.Timeout);
    end
    checks++;
    if (ifb.WMux !== 8'h00 || ifb.OutValid !== 1'b0 || ifb.Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_b: WMux=%h OutValid=%b Busy=%b, required 00/0/0",
               ifb.WMux, ifb.OutValid, ifb.Busy);
    end
  endtask

  task automatic test_direct_select();
    ifa.Sources = {8'h44, 8'h33, 8'h22, 8'h11};
    ifa.Sel = 2'd2; ifa.InValid = 1; ifa.IsLoad = 0;
    exp_a.push_back(8'h33);
    tick();
    ifa.InValid = 0;
    checks++;
    if (ifa.OutValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL direct_valid: OutValid=%b, required 1", ifa.OutValid);
    end else begin
      exp_v = exp_a.pop_front();
      checks++;
      if (ifa.WMux !== exp_v) begin
        errors++;
        $display("[TB] FAIL direct_data: WMux=%h, required %h", ifa.WMux, exp_v);
      end
    end
    tick();
    checks++;
    if (ifa.OutValid !== 1'b0 || ifa.WMux !== 8'h33) begin
      errors++;
      $display("[TB] FAIL direct_pulse: OutValid=%b WMux=%h, required 0/33", ifa.OutValid, ifa.WMux);
    end
  endtask

  task automatic test_load_wait();
    int busy_cycles = 0;
    ifa.Sources = {8'hA5, 8'h33, 8'h22, 8'h11};
    ifa.Sel = 2'd3; ifa.InValid = 1; ifa.IsLoad = 1; ifa.MemReady = 0;
    tick();
    ifa.InValid = 0; ifa.Sel = 2'd0; ifa.IsLoad = 0;
    if (ifa.Busy === 1'b1) busy_cycles++;
    tick();
    if (ifa.Busy === 1'b1) busy_cycles++;
    ifa.MemReady = 1;
    exp_a.push_back(8'hA5);
    tick();
    ifa.MemReady = 0;
    checks++;
    if (busy_cycles != 2) begin
      errors++;
      $display("[TB] FAIL load_busy_cycles: saw %0d busy cycles, required 2", busy_cycles);
    end
    checks++;
    if (ifa.OutValid !== 1'b1 || ifa.Busy !== 1'b0 || ifa.Timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done: OutValid=%b Busy=%b Timeout=%b, required 1/0/0",
               ifa.OutValid, ifa.Busy, ifa.Timeout);
    end else begin
      exp_v = exp_a.pop_front();
      checks++;
      if (ifa.WMux !== exp_v) begin
        errors++;
        $display("[TB] FAIL load_data: WMux=%h, required %h", ifa.WMux, exp_v);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    ifa.Sel = 2'd1; ifa.InValid = 1; ifa.IsLoad = 1; ifa.MemReady = 0;
    tick();
    ifa.InValid = 0; ifa.IsLoad = 0;
    // Wait pattern: two live cycles, one stalled cycle with MemReady high, then two live cycles
    for (int c = 0; c < 5; c++) begin
      ifa.Stall    = (c == 2);
      ifa.MemReady = (c == 2);
      tick();
      ifa.Stall = 0; ifa.MemReady = 0;
      if (c < 4) begin
        checks++;
        if (ifa.Busy !== 1'b1 || ifa.Timeout !== 1'b0 || ifa.OutValid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL timeout_wait%0d: Busy=%b Timeout=%b OutValid=%b, required 1/0/0",
                   c, ifa.Busy, ifa.Timeout, ifa.OutValid);
        end
      end
    end
    checks++;
    if (ifa.Timeout !== 1'b1 || ifa.Busy !== 1'b0 || ifa.OutValid !== 1'b0 || ifa.WMux !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL timeout_fire: Timeout=%b Busy=%b OutValid=%b WMux=%h, required 1/0/0/a5",
               ifa.Timeout, ifa.Busy, ifa.OutValid, ifa.WMux);
    end
    tick();
    checks++;
    if (ifa.Timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: Timeout=%b, required 0", ifa.Timeout);
    end
  endtask

  task automatic test_ready_on_deadline();
    ifa.Sources = {8'h44, 8'h33, 8'h22, 8'h11};
    ifa.Sel = 2'd1; ifa.InValid = 1; ifa.IsLoad = 1; ifa.MemReady = 0;
    tick();
    ifa.InValid = 0; ifa.IsLoad = 0;
    tick();
    tick();
    tick();
    ifa.MemReady = 1;
    exp_a.push_back(8'h22);
    tick();
    ifa.MemReady = 0;
    checks++;
    if (ifa.OutValid !== 1'b1 || ifa.Timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL deadline_ready: OutValid=%b Timeout=%b, required 1/0", ifa.OutValid, ifa.Timeout);
    end else begin
      exp_v = exp_a.pop_front();
      checks++;
      if (ifa.WMux !== exp_v) begin
        errors++;
        $display("[TB] FAIL deadline_data: WMux=%h, required %h", ifa.WMux, exp_v);
      end
    end
    tick();
  endtask

  task automatic test_flush();
    int bad = 0;
    ifa.Sel = 2'd0; ifa.InValid = 1; ifa.IsLoad = 0; ifa.Stall = 1;
    tick();
    ifa.Stall = 0;
    checks++;
    if (ifa.OutValid !== 1'b0 || ifa.WMux !== 8'h22) begin
      errors++;
      $display("[TB] FAIL stall_blocks: OutValid=%b WMux=%h, required 0/22", ifa.OutValid, ifa.WMux);
    end
    ifa.Flush = 1;
    tick();
    ifa.Flush = 0; ifa.InValid = 0;
    checks++;
    if (ifa.OutValid !== 1'b0 || ifa.Busy !== 1'b0 || ifa.WMux !== 8'h22) begin
      errors++;
      $display("[TB] FAIL flush_idle: OutValid=%b Busy=%b WMux=%h, required 0/0/22",
               ifa.OutValid, ifa.Busy, ifa.WMux);
    end
    ifa.Sel = 2'd3; ifa.InValid = 1; ifa.IsLoad = 1; ifa.MemReady = 0;
    tick();
    ifa.InValid = 0; ifa.IsLoad = 0;
    tick();
    ifa.Flush = 1; ifa.Stall = 1; ifa.MemReady = 1;
    tick();
    ifa.Flush = 0; ifa.Stall = 0; ifa.MemReady = 0;
    checks++;
    if (ifa.OutValid !== 1'b0 || ifa.Timeout !== 1'b0 || ifa.Busy !== 1'b0 || ifa.WMux !== 8'h22) begin
      errors++;
      $display("[TB] FAIL flush_wait: OutValid=%b Timeout=%b Busy=%b WMux=%h, required 0/0/0/22",
               ifa.OutValid, ifa.Timeout, ifa.Busy, ifa.WMux);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ifa.Timeout !== 1'b0 || ifa.OutValid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL flush_quiet: %0d cycles with activity, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_wait();
    int bad = 0;
    ifa.Sources = {8'h44, 8'h33, 8'h22, 8'h5A};
    ifa.Sel = 2'd0; ifa.InValid = 1; ifa.IsLoad = 0;
    exp_a.push_back(8'h5A);
    tick();
    checks++;
    if (ifa.OutValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prior_valid: OutValid=%b, required 1", ifa.OutValid);
    end else begin
      exp_v = exp_a.pop_front();
      checks++;
      if (ifa.WMux !== exp_v) begin
        errors++;
        $display("[TB] FAIL prior_data: WMux=%h, required %h", ifa.WMux, exp_v);
      end
    end
    ifa.Sel = 2'd2; ifa.IsLoad = 1; ifa.MemReady = 0;
    tick();
    ifa.InValid = 0; ifa.IsLoad = 0;
    Reset = 1; ifa.MemReady = 1;
    tick();
    Reset = 0; ifa.MemReady = 0;
    checks++;
    if (ifa.WMux !== 8'h00 || ifa.Busy !== 1'b0 || ifa.OutValid !== 1'b0 || ifa.Timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wait: WMux=%h Busy=%b OutValid=%b Timeout=%b, required 00/0/0/0",
               ifa.WMux, ifa.Busy, ifa.OutValid, ifa.Timeout);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ifa.Timeout !== 1'b0 || ifa.OutValid !== 1'b0 || ifa.Busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL reset_quiet: %0d cycles with activity, required 0", bad);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] seen;
    ifb.Sources = {8'h77, 8'h66, 8'h55};
    ifb.IsLoad = 0; ifb.InValid = 1;
    for (int s = 1; s < 4; s += 2) begin
      ifb.Sel = 2'(s);
      exp_b.push_back((s == 1) ? 8'h66 : 8'h00);
      tick();
      seen = ifb.WMux;
      checks++;
      if (ifb.OutValid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL range_valid sel=%0d: OutValid=%b, required 1", s, ifb.OutValid);
      end else begin
        exp_v = exp_b.pop_front();
        checks++;
        if (seen !== exp_v) begin
          errors++;
          $display("[TB] FAIL range_data sel=%0d: WMux=%h, required %h", s, seen, exp_v);
        end
      end
    end
    ifb.InValid = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] src [4];
    for (int i = 0; i < 4; i++) src[i] = 8'($urandom_range(1, 255));
    ifa.Sources = {src[3], src[2], src[1], src[0]};
    ifa.InValid = 1; ifa.IsLoad = 0;
    for (int k = 0; k < 8; k++) begin
      ifa.Sel = 2'((k * 3) % 4);
      ifa.IsLoad = k[0];
      ifa.MemReady = k[0];
      exp_a.push_back(src[(k * 3) % 4]);
      tick();
      checks++;
      if (ifa.OutValid !== 1'b1 || ifa.Busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_valid%0d: OutValid=%b Busy=%b, required 1/0", k, ifa.OutValid, ifa.Busy);
      end else begin
        exp_v = exp_a.pop_front();
        checks++;
        if (ifa.WMux !== exp_v) begin
          errors++;
          $display("[TB] FAIL b2b_data%0d: WMux=%h, required %h", k, ifa.WMux, exp_v);
        end
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (exp_a.size() + exp_b.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_a.size() + exp_b.size());
    end
  endtask

  initial begin
    Reset = 1;
    ifa.Sources = '0; ifa.Sel = '0;
    ifb.Sources = '0; ifb.Sel = '0;
    idle_inputs();
    test_reset();
    test_direct_select();
    test_load_wait();
    test_timeout();
    test_ready_on_deadline();
    test_flush();
    test_reset_mid_wait();
    test_out_of_range();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_back_sel.md
WRITE_BACK_SEL -- requirements
Module: write_back_sel

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: datapath width in bits.
- REQ-002 SHALL have parameter NUM_SRC, default 4, minimum 2: number of write-back sources; SEL_W = max(1, clog2(NUM_SRC)) is derived.
- REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, minimum 1: max non-stalled wait cycles for memory data.
- REQ-004 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port Reset, input, 1: synchronous, active-high reset.
- REQ-006 SHALL have port Sources, input, NUM_SRC*WIDTH: packed sources; source i = bits [(i+1)*WIDTH-1 : i*WIDTH].
- REQ-007 SHALL have port Sel, input, SEL_W: source index for the offered request.
- REQ-008 SHALL have port InValid, input, 1: write-back request offered this cycle.
- REQ-009 SHALL have port IsLoad, input, 1: selected source is memory data, gated by MemReady.
- REQ-010 SHALL have port MemReady, input, 1: memory data on the selected source is valid this cycle.
- REQ-011 SHALL have port Stall, input, 1: pipeline hold; blocks acceptance, capture and counting.
- REQ-012 SHALL have port Flush, input, 1: abandon any pending request.
- REQ-013 SHALL have port WMux, output, WIDTH: registered write-back value.
- REQ-014 SHALL have port OutValid, output, 1: one-cycle pulse, WMux freshly captured.
- REQ-015 SHALL have port Busy, output, 1: high in WAIT_MEM; request not accepted.
- REQ-016 SHALL have port Timeout, output, 1: one-cycle pulse, pending load abandoned on timeout.

Function
- REQ-017 SHALL implement a two-state FSM, IDLE and WAIT_MEM; Busy = (state == WAIT_MEM).
- REQ-018 SHALL accept a request when state is IDLE and InValid=1, Stall=0 and Flush=0; otherwise it is not accepted and upstream holds it.
- REQ-019 SHALL, on an accepted request with IsLoad=0, or with IsLoad=1 and MemReady=1, register Sources[Sel] into WMux and pulse OutValid the next cycle (1-cycle latency), remaining in IDLE.
- REQ-020 SHALL, on an accepted request with IsLoad=1 and MemReady=0, latch Sel, clear the wait counter and enter WAIT_MEM.
- REQ-021 SHALL, in WAIT_MEM with Stall=0 and MemReady=1, register Sources[latched Sel] into WMux, pulse OutValid next cycle and return to IDLE.
- REQ-022 SHALL, in WAIT_MEM with Stall=0 and MemReady=0, increment the counter; on the MEM_TIMEOUT-th such cycle return to IDLE and pulse Timeout next cycle, WMux unchanged, no OutValid.
- REQ-023 SHALL freeze state, counter and latched Sel while Stall=1; MemReady during Stall is ignored.
- REQ-024 SHALL ignore InValid, Sel and IsLoad while in WAIT_MEM.
- REQ-025 SHALL, on Flush=1 (not in reset), go to IDLE, clear counter, drop any same-cycle request, hold WMux, and drive OutValid=0 and Timeout=0 next cycle; Flush overrides Stall.
- REQ-026 SHALL give MemReady priority over timeout when both occur in the same cycle.
- REQ-027 SHALL capture all-zeros when the selected index is >= NUM_SRC, with normal OutValid.
- REQ-028 SHALL size the counter clog2(MEM_TIMEOUT+1) bits, never wrapping.
- REQ-029 SHALL never assert OutValid and Timeout in the same cycle; WMux changes only on an OutValid-producing capture.

Reset
- REQ-030 SHALL, when Reset=1 at a rising edge, set state IDLE, counter 0, latched Sel 0, WMux 0, OutValid 0, Busy 0, Timeout 0; Reset overrides Flush, Stall and all requests.
- REQ-031 SHALL, on Reset mid-WAIT_MEM, abandon the load without OutValid or Timeout.

Verification
- REQ-032 SHALL test: NUM_SRC=4, Sources={8'h44,8'h33,8'h22,8'h11}, Sel=2, InValid=1, IsLoad=0 -> next cycle WMux=8'h33, OutValid=1 one cycle.
- REQ-033 SHALL test: IsLoad=1, Sel=3, MemReady=0 for 2 cycles then 1 with source 3=8'hA5 -> Busy high 2 cycles, WMux=8'hA5, OutValid pulse, Busy low.
- REQ-034 SHALL test: MEM_TIMEOUT=4, IsLoad=1, MemReady held 0, one Stall cycle mid-wait -> Timeout pulses after exactly 4 non-stalled wait cycles, WMux unchanged, OutValid never high.
- REQ-035 SHALL test: in WAIT_MEM, MemReady=1 on the 4th (timeout) cycle -> OutValid=1, Timeout=0.
- REQ-036 SHALL test: Flush=1 with simultaneous InValid in IDLE, then Flush during WAIT_MEM -> no OutValid, no Timeout, Busy=0 next cycle, WMux retains prior value.
- REQ-037 SHALL test: Reset=1 during WAIT_MEM with prior WMux=8'h5A -> next cycle WMux=0, Busy=0, OutValid=0, Timeout=0; Sel=3 with NUM_SRC=3 -> WMux=0, OutValid=1.
